// File: rtl/dvp_pkg.sv
// Shared types and derived frame-geometry helpers for the DVP transmitter.
package dvp_pkg;

  localparam int DVP_DATA_W = 8;
  localparam int RGB_PXL_W  = 16;

  typedef struct packed {
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
  } rgb565_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dvp_tx_st_e;

  function automatic int frame_lines(input int vs_lines, input int vbp_lines,
                                     input int img_h, input int vfp_lines);
    return vs_lines + vbp_lines + img_h + vfp_lines;
  endfunction

  // HREF bounds are in PCLK periods; one pixel period is two PCLKs.
  function automatic int href_start(input int hs_low_tp, input int hbp_tp);
    return 2 * (hs_low_tp + hbp_tp);
  endfunction

  function automatic int href_end(input int hs_low_tp, input int hbp_tp, input int img_w);
    return href_start(hs_low_tp, hbp_tp) + 2 * img_w;
  endfunction

endpackage

// File: rtl/dvp_tx_timing_cnt.sv
// Horizontal/vertical position counters for the DVP frame and the
// combinational decode of sync, HREF, byte parity and pixel-fetch timing.
module dvp_tx_timing_cnt #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int LINE_TP   = 784,
  parameter int HS_LOW_TP = 80,
  parameter int HBP_TP    = 40,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic vsync,
  output logic hsync,
  output logic href,
  output logic byte_odd,
  output logic fetch,
  output logic frame_wrap
);
  import dvp_pkg::*;

  localparam int H_TOTAL     = 2 * LINE_TP;
  localparam int FRAME_LINES = frame_lines(VS_LINES, VBP_LINES, IMG_H, VFP_LINES);
  localparam int HW          = $clog2(H_TOTAL);
  localparam int VW          = $clog2(FRAME_LINES);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_END = HW'(2 * HS_LOW_TP);
  localparam logic [HW-1:0] HREF_S = HW'(href_start(HS_LOW_TP, HBP_TP));
  localparam logic [HW-1:0] HREF_E = HW'(href_end(HS_LOW_TP, HBP_TP, IMG_W));
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);
  localparam logic [VW-1:0] VS_END = VW'(VS_LINES);
  localparam logic [VW-1:0] ACT_S  = VW'(VS_LINES + VBP_LINES);
  localparam logic [VW-1:0] ACT_E  = VW'(VS_LINES + VBP_LINES + IMG_H);

  logic [HW-1:0] h_cnt;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          line_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      h_cnt <= h_nxt;
      if (h_wrap) begin
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end
    end
  end

  // HREF_S is always even, so byte parity within the line is just h_cnt[0];
  // fetch looks one PCLK ahead so the pixel is in place for the even byte.
  always_comb begin
    h_wrap      = (h_cnt == H_LAST);
    h_nxt       = h_wrap ? '0 : h_cnt + HW'(1);
    line_active = (v_cnt >= ACT_S) && (v_cnt < ACT_E);
    vsync       = (v_cnt < VS_END);
    hsync       = (h_cnt >= HS_END);
    href        = line_active && (h_cnt >= HREF_S) && (h_cnt < HREF_E);
    byte_odd    = h_cnt[0];
    fetch       = line_active && (h_nxt >= HREF_S) && (h_nxt < HREF_E) && !h_nxt[0];
    frame_wrap  = tick && h_wrap && (v_cnt == V_LAST);
  end

endmodule

// File: rtl/dvp_tx_generator.sv
// DVP camera-side transmitter: turns a valid/ready RGB565 stream into an
// OV7670-style byte-wide frame with PCLK running at half the system clock.
module dvp_tx_generator #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int LINE_TP    = 784,
  parameter int HS_LOW_TP  = 80,
  parameter int HBP_TP     = 40,
  parameter int VS_LINES   = 3,
  parameter int VBP_LINES  = 17,
  parameter int VFP_LINES  = 10,
  parameter int DVP_DATA_W = dvp_pkg::DVP_DATA_W,
  parameter int RGB_PXL_W  = dvp_pkg::RGB_PXL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dvp_pwdn_i,
  input  logic [RGB_PXL_W-1:0]  pxl_data_i,
  input  logic                  pxl_valid_i,
  output logic                  pxl_ready_o,
  output logic                  dvp_pclk_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_hsync_o,
  output logic                  dvp_href_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);
  import dvp_pkg::*;

  dvp_tx_st_e state_q;
  dvp_tx_st_e state_d;
  logic       run;

  logic       ph_q;
  logic       fall_tick;
  logic       pclk_q;
  logic       vsync_q;
  logic       hsync_q;
  logic       href_q;
  logic [DVP_DATA_W-1:0] d_q;
  logic       ready_q;
  logic       frame_done_q;
  logic       underrun_q;
  rgb565_t    hold_q;

  logic t_vsync;
  logic t_hsync;
  logic t_href;
  logic t_byte_odd;
  logic t_fetch;
  logic t_frame_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!dvp_pwdn_i) state_d = RUN;
      RUN:     if (dvp_pwdn_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Power-down takes effect on the very next edge, so it gates RUN directly.
  always_comb begin
    run       = (state_q == RUN) && !dvp_pwdn_i;
    fall_tick = run && !ph_q;
  end

  dvp_tx_timing_cnt #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .LINE_TP   (LINE_TP),
    .HS_LOW_TP (HS_LOW_TP),
    .HBP_TP    (HBP_TP),
    .VS_LINES  (VS_LINES),
    .VBP_LINES (VBP_LINES),
    .VFP_LINES (VFP_LINES)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!run),
    .tick       (fall_tick),
    .vsync      (t_vsync),
    .hsync      (t_hsync),
    .href       (t_href),
    .byte_odd   (t_byte_odd),
    .fetch      (t_fetch),
    .frame_wrap (t_frame_wrap)
  );

  // pclk_q lags ph_q by one clk, so the first RUN edge is a falling edge
  // that launches h_cnt=0 and PCLK first rises one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q         <= 1'b0;
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (!run) begin
      ph_q         <= 1'b0;
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ph_q         <= ~ph_q;
      pclk_q       <= ph_q;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (fall_tick) begin
        vsync_q      <= t_vsync;
        hsync_q      <= t_hsync;
        href_q       <= t_href;
        d_q          <= !t_href    ? '0 :
                        t_byte_odd ? hold_q[DVP_DATA_W-1:0] :
                                     hold_q[RGB_PXL_W-1 -: DVP_DATA_W];
        ready_q      <= t_fetch;
        frame_done_q <= t_frame_wrap;
      end
    end
  end

  // A missing pixel is replaced by black rather than stalling the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      underrun_q <= 1'b0;
    end else if (run && ready_q) begin
      if (pxl_valid_i) begin
        hold_q <= rgb565_t'(pxl_data_i);
      end else begin
        hold_q     <= '0;
        underrun_q <= 1'b1;
      end
    end
  end

  assign pxl_ready_o  = ready_q;
  assign dvp_pclk_o   = pclk_q;
  assign dvp_vsync_o  = vsync_q;
  assign dvp_hsync_o  = hsync_q;
  assign dvp_href_o   = href_q;
  assign dvp_d_o      = d_q;
  assign frame_done_o = frame_done_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_dvp_tx_generator.sv
// Scoreboard bench for dvp_tx_generator with a reduced frame geometry;
// pixel bytes are queued at each handshake and popped at PCLK rises.
module tb_dvp_tx_generator;

  localparam int IMG_W     = 4;
  localparam int IMG_H     = 2;
  localparam int LINE_TP   = 10;
  localparam int HS_LOW_TP = 2;
  localparam int HBP_TP    = 1;
  localparam int VS_LINES  = 1;
  localparam int VBP_LINES = 1;
  localparam int VFP_LINES = 1;

  localparam int H_PCLK      = 2 * LINE_TP;
  localparam int FRAME_LINES = VS_LINES + VBP_LINES + IMG_H + VFP_LINES;
  localparam int FRAME_PCLK  = H_PCLK * FRAME_LINES;
  localparam int PIX_FRAME   = IMG_W * IMG_H;
  localparam int HREF_FIRST  = 2 * (HS_LOW_TP + HBP_TP);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dvp_pwdn_i = 1'b0;
  logic [15:0] pxl_data_i = 16'h0000;
  logic        pxl_valid_i = 1'b0;
  logic        pxl_ready_o;
  logic        dvp_pclk_o;
  logic        dvp_vsync_o;
  logic        dvp_hsync_o;
  logic        dvp_href_o;
  logic [7:0]  dvp_d_o;
  logic        frame_done_o;
  logic        underrun_o;

  int n_checks = 0;
  int n_errors = 0;

  int         n_rise = 0;
  int         fd_count = 0;
  int         hs_in_frame = 0;
  int         pix_k = 0;
  logic [7:0] exp_q[$];
  logic       exp_under = 1'b0;
  logic       drop_armed = 1'b0;

  logic       prev_pclk = 1'b0;
  logic       prev_vs = 1'b0;
  logic       prev_hs = 1'b0;
  logic       prev_href = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_fd = 1'b0;

  dvp_tx_generator #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .LINE_TP   (LINE_TP),
    .HS_LOW_TP (HS_LOW_TP),
    .HBP_TP    (HBP_TP),
    .VS_LINES  (VS_LINES),
    .VBP_LINES (VBP_LINES),
    .VFP_LINES (VFP_LINES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dvp_pwdn_i   (dvp_pwdn_i),
    .pxl_data_i   (pxl_data_i),
    .pxl_valid_i  (pxl_valid_i),
    .pxl_ready_o  (pxl_ready_o),
    .dvp_pclk_o   (dvp_pclk_o),
    .dvp_vsync_o  (dvp_vsync_o),
    .dvp_hsync_o  (dvp_hsync_o),
    .dvp_href_o   (dvp_href_o),
    .dvp_d_o      (dvp_d_o),
    .frame_done_o (frame_done_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pixel(input int k);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(32'hA1 + 32'h22 * k);
    lo = 8'(32'hB2 + 32'h22 * k);
    return {hi, lo};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_pclk"},   32'(dvp_pclk_o),   32'd0);
    checkOutput({tag, "_vsync"},  32'(dvp_vsync_o),  32'd0);
    checkOutput({tag, "_hsync"},  32'(dvp_hsync_o),  32'd0);
    checkOutput({tag, "_href"},   32'(dvp_href_o),   32'd0);
    checkOutput({tag, "_d"},      32'(dvp_d_o),      32'd0);
    checkOutput({tag, "_ready"},  32'(pxl_ready_o),  32'd0);
    checkOutput({tag, "_fdone"},  32'(frame_done_o), 32'd0);
    checkOutput({tag, "_underr"}, 32'(underrun_o),   32'd0);
  endtask

  // One system clock: sample at the falling clk edge, check against the
  // frame model on PCLK rises, then act as the pixel source.
  task automatic step();
    int   h;
    int   v;
    logic act;
    logic e_vs;
    logic e_hs;
    logic e_href;
    logic [7:0] e_d;
    @(negedge clk);
    if (!rst_n || dvp_pwdn_i) begin
      n_rise      = 0;
      fd_count    = 0;
      hs_in_frame = 0;
      exp_q.delete();
    end else begin
      if (dvp_pclk_o && !prev_pclk) begin
        checkOutput("stable_at_rise", 32'({dvp_vsync_o, dvp_hsync_o, dvp_href_o, dvp_d_o}),
                    32'({prev_vs, prev_hs, prev_href, prev_d}));
        h      = n_rise % H_PCLK;
        v      = (n_rise / H_PCLK) % FRAME_LINES;
        e_vs   = (v < VS_LINES);
        e_hs   = (h >= 2 * HS_LOW_TP);
        act    = (v >= VS_LINES + VBP_LINES) && (v < VS_LINES + VBP_LINES + IMG_H);
        e_href = act && (h >= HREF_FIRST) && (h < HREF_FIRST + 2 * IMG_W);
        checkOutput("vsync", 32'(dvp_vsync_o), 32'(e_vs));
        checkOutput("hsync", 32'(dvp_hsync_o), 32'(e_hs));
        checkOutput("href",  32'(dvp_href_o),  32'(e_href));
        if (e_href) begin
          if (exp_q.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
          end else begin
            e_d = exp_q.pop_front();
            checkOutput("data", 32'(dvp_d_o), 32'(e_d));
          end
        end else begin
          checkOutput("data_blank", 32'(dvp_d_o), 32'd0);
        end
        checkOutput("underrun", 32'(underrun_o), 32'(exp_under));
        n_rise++;
      end
      if (frame_done_o) begin
        checkOutput("fd_position", 32'(n_rise), 32'(fd_count * FRAME_PCLK + FRAME_PCLK - 1));
        checkOutput("fd_handshakes", 32'(hs_in_frame), 32'(PIX_FRAME));
        checkOutput("fd_one_clk", 32'(prev_fd), 32'd0);
        fd_count++;
        hs_in_frame = 0;
      end
      if (pxl_ready_o) begin
        hs_in_frame++;
        if (drop_armed && hs_in_frame == 2) begin
          pxl_valid_i = 1'b0;
          pxl_data_i  = 16'hFFFF;
          exp_q.push_back(8'h00);
          exp_q.push_back(8'h00);
          exp_under   = 1'b1;
          drop_armed  = 1'b0;
        end else begin
          pxl_valid_i = 1'b1;
          pxl_data_i  = pixel(pix_k);
          exp_q.push_back(pxl_data_i[15:8]);
          exp_q.push_back(pxl_data_i[7:0]);
          pix_k++;
        end
      end else begin
        pxl_valid_i = 1'b1;
        pxl_data_i  = pixel(pix_k);
      end
    end
    prev_pclk = dvp_pclk_o;
    prev_vs   = dvp_vsync_o;
    prev_hs   = dvp_hsync_o;
    prev_href = dvp_href_o;
    prev_d    = dvp_d_o;
    prev_fd   = frame_done_o;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic waitHref(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (dvp_href_o) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    dvp_pwdn_i  = 1'b0;
    pxl_valid_i = 1'b1;
    pxl_data_i  = pixel(0);
    applyStimulus(3);
    checkIdle("reset");

    $display("[TB] two frames, source always valid");
    rst_n = 1'b1;
    applyStimulus(4 * FRAME_PCLK + 40);

    $display("[TB] power-down mid-line");
    waitHref("pwdn_href_wait", 4 * H_PCLK);
    dvp_pwdn_i = 1'b1;
    step();
    checkIdle("pwdn");
    applyStimulus(3);
    checkIdle("pwdn_hold");
    drop_armed = 1'b1;
    dvp_pwdn_i = 1'b0;
    step();
    checkOutput("rel_vsync_1st_clk", 32'(dvp_vsync_o), 32'd0);
    checkOutput("rel_pclk_1st_clk",  32'(dvp_pclk_o),  32'd0);
    step();
    checkOutput("rel_vsync_2nd_clk", 32'(dvp_vsync_o), 32'd1);
    checkOutput("rel_hsync_2nd_clk", 32'(dvp_hsync_o), 32'd0);
    checkOutput("rel_pclk_2nd_clk",  32'(dvp_pclk_o),  32'd0);
    step();
    checkOutput("rel_pclk_first_rise", 32'(dvp_pclk_o), 32'd1);

    $display("[TB] frame with one missing pixel");
    applyStimulus(2 * FRAME_PCLK + 20);
    checkOutput("underrun_sticky", 32'(underrun_o), 32'd1);

    $display("[TB] asynchronous reset during HREF");
    waitHref("rst_href_wait", 4 * H_PCLK);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("async_rst");
    exp_under = 1'b0;
    step();
    rst_n = 1'b1;
    applyStimulus(2 * FRAME_PCLK + 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
